// File: rtl/mem_port_arbiter_if.sv
// Bundles the fetch, data, flush and unified-memory signals shared by the arbiter and its surroundings.
// Handshake: a requester holds req (plus address/data) stable until its ack, a one-cycle pulse; mem_req
// and its payload stay stable until a cycle with mem_ready=1, which completes the transaction.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_ack;
  logic [DATA_W-1:0] dm_rdata;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;
  logic              stall_if;
  logic              stall_mem;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, flush, mem_rdata, mem_ready,
    output if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, flush, mem_rdata, mem_ready,
    input  if_ack, if_rdata, dm_ack, dm_rdata, mem_req, mem_we, mem_addr, mem_wdata,
           stall_if, stall_mem
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data load/store onto one single-ported variable-latency memory,
// with data priority bounded by a starvation counter and flush-driven dropping of fetch responses.
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  mem_port_arbiter_if.master                   io_bus,
  output logic [1:0]                           o_dbg_state,
  output logic [$clog2(MAX_DATA_BURST+1)-1:0]  o_dbg_starve_cnt,
  output logic                                 o_dbg_drop
);
  localparam int                CNT_W      = $clog2(MAX_DATA_BURST + 1);
  localparam logic [CNT_W-1:0]  STARVE_MAX = CNT_W'(MAX_DATA_BURST);
  localparam logic [1:0]        S_IDLE     = 2'd0;
  localparam logic [1:0]        S_FETCH    = 2'd1;
  localparam logic [1:0]        S_DATA     = 2'd2;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_starve_cnt;
  logic              r_drop;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              w_grant_data;
  logic              w_grant_fetch;
  logic              w_if_ack;
  logic              w_dm_ack;

  // Data wins ties unless fetch has already waited through MAX_DATA_BURST data grants.
  always_comb begin
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;
    if (r_state == S_IDLE) begin
      w_grant_data  = io_bus.dm_req & (~io_bus.if_req | (r_starve_cnt != STARVE_MAX));
      w_grant_fetch = io_bus.if_req & ~w_grant_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_starve_cnt <= '0;
      r_drop       <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_data) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= io_bus.dm_we;
            r_mem_addr  <= io_bus.dm_addr;
            r_mem_wdata <= io_bus.dm_wdata;
            r_state     <= S_DATA;
            if (!io_bus.if_req)
              r_starve_cnt <= '0;
            else if (r_starve_cnt != STARVE_MAX)
              r_starve_cnt <= r_starve_cnt + 1'b1;
          end else if (w_grant_fetch) begin
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= io_bus.if_addr;
            r_mem_wdata  <= '0;
            r_state      <= S_FETCH;
            r_starve_cnt <= '0;
          end
        end
        S_FETCH: begin
          // A flush on the completion cycle is masked combinationally, so drop only needs to cover later cycles.
          if (io_bus.mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
            r_drop    <= 1'b0;
          end else if (io_bus.flush) begin
            r_drop <= 1'b1;
          end
        end
        S_DATA: begin
          if (io_bus.mem_ready) begin
            r_mem_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_mem_req <= 1'b0;
          r_drop    <= 1'b0;
        end
      endcase
    end
  end

  assign w_if_ack = (r_state == S_FETCH) & io_bus.mem_ready & ~r_drop & ~io_bus.flush;
  assign w_dm_ack = (r_state == S_DATA) & io_bus.mem_ready;

  assign io_bus.if_ack    = w_if_ack;
  assign io_bus.dm_ack    = w_dm_ack;
  assign io_bus.if_rdata  = io_bus.mem_rdata;
  assign io_bus.dm_rdata  = io_bus.mem_rdata;
  assign io_bus.stall_if  = io_bus.if_req & ~w_if_ack;
  assign io_bus.stall_mem = io_bus.dm_req & ~w_dm_ack;
  assign io_bus.mem_req   = r_mem_req;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_wdata = r_mem_wdata;

  assign o_dbg_state      = r_state;
  assign o_dbg_starve_cnt = r_starve_cnt;
  assign o_dbg_drop       = r_drop;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a randomized
// transaction-level reference model of arbitration, starvation and flush dropping.
module tb_mem_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int MAXB   = 4;
  localparam int CNT_W  = $clog2(MAXB + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       dbg_state;
  logic [CNT_W-1:0] dbg_starve;
  logic             dbg_drop;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] exp_q[$];

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DATA_BURST(MAXB)) dut (
    .clk              (clk),
    .rst              (rst),
    .io_bus           (bus),
    .o_dbg_state      (dbg_state),
    .o_dbg_starve_cnt (dbg_starve),
    .o_dbg_drop       (dbg_drop)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.dm_req    = 1'b0;
    bus.dm_we     = 1'b0;
    bus.dm_addr   = '0;
    bus.dm_wdata  = '0;
    bus.flush     = 1'b0;
    bus.mem_rdata = '0;
    bus.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
    n_tests++; if (bus.mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_mem_we: got %b want 0", bus.mem_we); end
    n_tests++; if (bus.mem_addr !== '0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
    n_tests++; if (bus.mem_wdata !== '0) begin n_fail++; $display("FAIL rst_mem_wdata: got %h want 0", bus.mem_wdata); end
    n_tests++; if (dbg_state !== 2'd0 || dbg_starve !== '0 || dbg_drop !== 1'b0) begin
      n_fail++; $display("FAIL rst_state: got state=%0d starve=%0d drop=%b want 0/0/0", dbg_state, dbg_starve, dbg_drop);
    end
    bus.if_req = 1'b1; bus.dm_req = 1'b1; bus.mem_ready = 1'b1;
    #1;
    n_tests++; if (bus.stall_if !== 1'b1 || bus.stall_mem !== 1'b1 || bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0) begin
      n_fail++; $display("FAIL rst_stall: got sif=%b smem=%b ifack=%b dmack=%b want 1/1/0/0",
                         bus.stall_if, bus.stall_mem, bus.if_ack, bus.dm_ack);
    end
    idle_inputs();
    #1; rst = 1'b0;
    // Start a load and reset it while the memory is finishing it.
    tick();
    bus.dm_req = 1'b1; bus.dm_addr = 32'h300;
    tick();
    @(negedge clk);
    n_tests++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rst_pre_req: got %b want 1", bus.mem_req); end
    #1; bus.mem_ready = 1'b1;
    #1;
    n_tests++; if (bus.dm_ack !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack: got %b want 1", bus.dm_ack); end
    rst = 1'b1;
    #1;
    n_tests++; if (bus.mem_req !== 1'b0 || bus.dm_ack !== 1'b0 || bus.if_ack !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL rst_mid_data: got req=%b dmack=%b ifack=%b state=%0d want 0/0/0/0",
                         bus.mem_req, bus.dm_ack, bus.if_ack, dbg_state);
    end
    idle_inputs();
    #1; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      n_tests++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_idle_req[%0d]: got %b want 0", i, bus.mem_req); end
    end
  endtask

  task automatic test_single_fetch();
    tick();
    idle_inputs();
    bus.mem_ready = 1'b1; bus.mem_rdata = 32'h00A00093;
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    @(negedge clk);
    n_tests++; if (bus.mem_req !== 1'b0 || bus.stall_if !== 1'b1 || bus.if_ack !== 1'b0) begin
      n_fail++; $display("FAIL fetch_c0: got req=%b stall=%b ack=%b want 0/1/0", bus.mem_req, bus.stall_if, bus.if_ack);
    end
    tick();
    @(negedge clk);
    n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h40 || bus.mem_we !== 1'b0 || bus.mem_wdata !== '0) begin
      n_fail++; $display("FAIL fetch_c1_bus: got req=%b addr=%h we=%b wd=%h want 1/40/0/0",
                         bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata);
    end
    n_tests++; if (bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h00A00093 || bus.stall_if !== 1'b0) begin
      n_fail++; $display("FAIL fetch_c1_ack: got ack=%b rdata=%h stall=%b want 1/00a00093/0",
                         bus.if_ack, bus.if_rdata, bus.stall_if);
    end
    tick();
    bus.if_req = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.mem_req !== 1'b0 || bus.if_ack !== 1'b0) begin
      n_fail++; $display("FAIL fetch_c2: got req=%b ack=%b want 0/0", bus.mem_req, bus.if_ack);
    end
  endtask

  task automatic test_store_wait();
    tick();
    idle_inputs();
    bus.dm_req = 1'b1; bus.dm_we = 1'b1; bus.dm_addr = 32'h100; bus.dm_wdata = 32'hDEADBEEF;
    bus.mem_rdata = $urandom;
    @(negedge clk);
    n_tests++; if (bus.stall_mem !== 1'b1 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL store_c0: got stall=%b req=%b want 1/0", bus.stall_mem, bus.mem_req);
    end
    for (int j = 0; j < 4; j++) begin
      tick();
      bus.mem_ready = (j == 3);
      @(negedge clk);
      n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h100 || bus.mem_wdata !== 32'hDEADBEEF || bus.mem_we !== 1'b1) begin
        n_fail++; $display("FAIL store_bus[%0d]: got req=%b addr=%h wd=%h we=%b want 1/100/deadbeef/1",
                           j, bus.mem_req, bus.mem_addr, bus.mem_wdata, bus.mem_we);
      end
      n_tests++; if (bus.dm_ack !== (j == 3) || bus.stall_mem !== (j != 3)) begin
        n_fail++; $display("FAIL store_ack[%0d]: got ack=%b stall=%b want %b/%b", j, bus.dm_ack, bus.stall_mem, j == 3, j != 3);
      end
    end
    tick();
    bus.dm_req = 1'b0; bus.mem_ready = 1'b0;
    @(negedge clk);
    n_tests++; if (bus.mem_req !== 1'b0 || bus.dm_ack !== 1'b0 || bus.mem_addr !== 32'h100) begin
      n_fail++; $display("FAIL store_after: got req=%b ack=%b addr=%h want 0/0/100", bus.mem_req, bus.dm_ack, bus.mem_addr);
    end
  endtask

  task automatic test_starvation();
    int st;
    logic [CNT_W-1:0] st_q[$];
    logic [DATA_W-1:0] exp_a;
    logic [CNT_W-1:0] exp_s;
    // Reference: data wins while fetch has waited fewer than MAXB grants, otherwise fetch once.
    st = 0;
    for (int g = 0; g < 10; g++) begin
      if (st < MAXB) begin
        exp_q.push_back(32'h2000);
        st = st + 1;
      end else begin
        exp_q.push_back(32'h1000);
        st = 0;
      end
      st_q.push_back(CNT_W'(st));
    end
    tick();
    idle_inputs();
    bus.mem_ready = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 32'h1000;
    bus.dm_req = 1'b1; bus.dm_addr = 32'h2000;
    for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
      bus.mem_rdata = $urandom;
      @(negedge clk);
      if (bus.mem_req === 1'b1) begin
        exp_a = exp_q.pop_front();
        exp_s = st_q.pop_front();
        n_tests++; if (bus.mem_addr !== exp_a) begin
          n_fail++; $display("FAIL starve_order: got addr=%h want %h", bus.mem_addr, exp_a);
        end
        n_tests++; if (dbg_starve !== exp_s) begin
          n_fail++; $display("FAIL starve_cnt: got %0d want %0d", dbg_starve, exp_s);
        end
        n_tests++; if (bus.dm_ack !== (exp_a == 32'h2000) || bus.if_ack !== (exp_a == 32'h1000)) begin
          n_fail++; $display("FAIL starve_ack: got dm=%b if=%b for addr %h", bus.dm_ack, bus.if_ack, exp_a);
        end
      end
      tick();
    end
    n_tests++; if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL starve_timeout: got %0d grants left want 0", exp_q.size());
    end
    exp_q.delete();
    idle_inputs();
    tick();
  endtask

  task automatic test_flush_during_fetch();
    tick();
    idle_inputs();
    bus.if_req = 1'b1; bus.if_addr = 32'h80; bus.mem_rdata = 32'h11111111;
    tick();
    bus.flush = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.if_ack !== 1'b0 || bus.mem_addr !== 32'h80) begin
      n_fail++; $display("FAIL flush_w0: got ack=%b addr=%h want 0/80", bus.if_ack, bus.mem_addr);
    end
    tick();
    bus.flush = 1'b0; bus.if_addr = 32'h200;
    @(negedge clk);
    n_tests++; if (bus.if_ack !== 1'b0 || dbg_drop !== 1'b1) begin
      n_fail++; $display("FAIL flush_w1: got ack=%b drop=%b want 0/1", bus.if_ack, dbg_drop);
    end
    tick();
    bus.mem_ready = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.if_ack !== 1'b0 || bus.mem_req !== 1'b1 || bus.stall_if !== 1'b1) begin
      n_fail++; $display("FAIL flush_done: got ack=%b req=%b stall=%b want 0/1/1", bus.if_ack, bus.mem_req, bus.stall_if);
    end
    tick();
    bus.mem_rdata = 32'h22222222;
    @(negedge clk);
    n_tests++; if (bus.mem_req !== 1'b0 || bus.if_ack !== 1'b0 || dbg_drop !== 1'b0) begin
      n_fail++; $display("FAIL flush_idle: got req=%b ack=%b drop=%b want 0/0/0", bus.mem_req, bus.if_ack, dbg_drop);
    end
    tick();
    @(negedge clk);
    n_tests++; if (bus.mem_addr !== 32'h200 || bus.if_ack !== 1'b1 || bus.if_rdata !== 32'h22222222) begin
      n_fail++; $display("FAIL flush_refetch: got addr=%h ack=%b rdata=%h want 200/1/22222222",
                         bus.mem_addr, bus.if_ack, bus.if_rdata);
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_flush_at_completion();
    tick();
    idle_inputs();
    bus.if_req = 1'b1; bus.if_addr = 32'h300;
    tick();
    tick();
    bus.mem_ready = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    n_tests++; if (bus.if_ack !== 1'b0 || bus.stall_if !== 1'b1) begin
      n_fail++; $display("FAIL flushc_ack: got ack=%b stall=%b want 0/1", bus.if_ack, bus.stall_if);
    end
    tick();
    idle_inputs();
    @(negedge clk);
    n_tests++; if (dbg_state !== 2'd0 || dbg_drop !== 1'b0 || bus.mem_req !== 1'b0) begin
      n_fail++; $display("FAIL flushc_exit: got state=%0d drop=%b req=%b want 0/0/0", dbg_state, dbg_drop, bus.mem_req);
    end
  endtask

  task automatic test_random();
    int model_starve;
    bit if_pend, dm_pend, take_data, flushed;
    logic [ADDR_W-1:0] if_a, dm_a, exp_addr;
    logic [DATA_W-1:0] dm_wd, exp_wd;
    bit dm_w, exp_we;
    int k, flush_at;
    model_starve = 0; if_pend = 0; dm_pend = 0;
    if_a = '0; dm_a = '0; dm_wd = '0; dm_w = 0;
    for (int t = 0; t < 150; t++) begin
      tick();
      if (!if_pend && $urandom_range(0, 2) != 0) begin if_pend = 1; if_a = $urandom & 32'hFFFF_FFFC; end
      if (!dm_pend && $urandom_range(0, 2) != 0) begin
        dm_pend = 1; dm_a = $urandom & 32'hFFFF_FFFC; dm_wd = $urandom; dm_w = $urandom_range(0, 1);
      end
      bus.if_req = if_pend; bus.if_addr = if_a;
      bus.dm_req = dm_pend; bus.dm_addr = dm_a; bus.dm_wdata = dm_wd; bus.dm_we = dm_w;
      bus.mem_ready = $urandom_range(0, 1);
      bus.flush = $urandom_range(0, 7) == 0;
      @(negedge clk);
      n_tests++; if (bus.mem_req !== 1'b0 || bus.if_ack !== 1'b0 || bus.dm_ack !== 1'b0 ||
                     bus.stall_if !== if_pend || bus.stall_mem !== dm_pend) begin
        n_fail++; $display("FAIL rnd_idle[%0d]: got req=%b ifack=%b dmack=%b sif=%b smem=%b want 0/0/0/%b/%b",
                           t, bus.mem_req, bus.if_ack, bus.dm_ack, bus.stall_if, bus.stall_mem, if_pend, dm_pend);
      end
      if (!if_pend && !dm_pend) continue;
      take_data = dm_pend && !(if_pend && model_starve == MAXB);
      if (take_data) begin
        exp_addr = dm_a; exp_we = dm_w; exp_wd = dm_wd;
        model_starve = if_pend ? ((model_starve < MAXB) ? model_starve + 1 : MAXB) : 0;
      end else begin
        exp_addr = if_a; exp_we = 0; exp_wd = '0;
        model_starve = 0;
      end
      k = $urandom_range(0, 3);
      flush_at = $urandom_range(0, 6);
      flushed = 0;
      for (int j = 0; j <= k; j++) begin
        tick();
        bus.mem_ready = (j == k);
        bus.mem_rdata = $urandom;
        bus.flush = (j == flush_at);
        if (!take_data && j == flush_at) flushed = 1;
        @(negedge clk);
        n_tests++; if (bus.mem_req !== 1'b1 || bus.mem_addr !== exp_addr || bus.mem_we !== exp_we || bus.mem_wdata !== exp_wd) begin
          n_fail++; $display("FAIL rnd_bus[%0d.%0d]: got req=%b addr=%h we=%b wd=%h want 1/%h/%b/%h",
                             t, j, bus.mem_req, bus.mem_addr, bus.mem_we, bus.mem_wdata, exp_addr, exp_we, exp_wd);
        end
        n_tests++; if (bus.dm_ack !== (take_data && j == k) || bus.if_ack !== (!take_data && j == k && !flushed)) begin
          n_fail++; $display("FAIL rnd_ack[%0d.%0d]: got dm=%b if=%b want %b/%b",
                             t, j, bus.dm_ack, bus.if_ack, take_data && j == k, !take_data && j == k && !flushed);
        end
        if (j == k) begin
          n_tests++; if ((take_data ? bus.dm_rdata : bus.if_rdata) !== bus.mem_rdata) begin
            n_fail++; $display("FAIL rnd_rdata[%0d]: got %h want %h", t, take_data ? bus.dm_rdata : bus.if_rdata, bus.mem_rdata);
          end
        end
      end
      n_tests++; if (dbg_starve !== CNT_W'(model_starve)) begin
        n_fail++; $display("FAIL rnd_starve[%0d]: got %0d want %0d", t, dbg_starve, model_starve);
      end
      // A flushed fetch stays pending, re-presented at a new PC.
      if (take_data) dm_pend = 0;
      else if (flushed) if_a = $urandom & 32'hFFFF_FFFC;
      else if_pend = 0;
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_fetch();
    test_store_wait();
    test_starvation();
    test_flush_during_fetch();
    test_flush_at_completion();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
